rf_access_arbiter: RTL and testbench
====================================

RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter STARVE_MAX, default 8, pending-debug cycles before a forced grant (range 1..255).
REQ-003 clk  input  1  core clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 core_we / core_waddr / core_wdata  input  1/5/XLEN  core writeback request; core holds these while core_stall=1.
REQ-006 dbg_req  input  1  debug access request; requester holds it and its qualifiers until dbg_gnt.
REQ-007 dbg_we / dbg_addr / dbg_wdata  input  1/5/XLEN  debug write-enable (0 = read), register index, write data.
REQ-008 rf_rdata  input  XLEN  combinational data from the register-file read port addressed by rf_raddr.
REQ-009 rf_we / rf_waddr / rf_wdata  output  1/5/XLEN  register-file write port.
REQ-010 rf_raddr  output  5  register-file debug read address.
REQ-011 dbg_gnt  output  1  debug access performed this cycle.
REQ-012 dbg_rvalid / dbg_rdata  output  1/XLEN  debug read response, one-cycle pulse.
REQ-013 core_stall  output  1  core writeback blocked this cycle.

Function
REQ-014 FSM states IDLE, GRANT, RESP; state register sole sequential control element plus starvation counter and dbg_rdata register.
REQ-015 IDLE -> GRANT when dbg_req=1 and (core_we=0 or starvation threshold reached); otherwise remain IDLE.
REQ-016 GRANT -> RESP if dbg_we=0; GRANT -> IDLE if dbg_we=1; RESP -> IDLE unconditionally.
REQ-017 IDLE/RESP: rf_we=core_we and (core_waddr!=0), rf_waddr=core_waddr, rf_wdata=core_wdata, core_stall=0.
REQ-018 GRANT: dbg_gnt=1, core_stall=1, rf_we=dbg_we and (dbg_addr!=0), rf_waddr=dbg_addr, rf_wdata=dbg_wdata, rf_raddr=dbg_addr.
REQ-019 GRANT read: dbg_rdata registered at end of GRANT from rf_rdata, forced 0 when dbg_addr=0; dbg_rvalid=1 only in RESP.
REQ-020 Latency: debug write committed 1 cycle after request acceptance; debug read data valid 2 cycles after acceptance.
REQ-021 Core priority: a cycle with core_we=1 in IDLE is never granted to debug unless the starvation threshold is reached.
REQ-022 dbg_req dropped while in IDLE before grant: request abandoned, no grant, counter cleared.
REQ-023 rf_raddr outside GRANT = dbg_addr (don't-care to RF); dbg_rdata holds last value until next read.
REQ-024 Simultaneous core_we and debug grant: core write deferred via core_stall, never dropped.

Reset
REQ-025 rst=0 forces state IDLE, counter 0, dbg_rdata 0; dbg_gnt, dbg_rvalid, core_stall = 0 immediately (async).
REQ-026 Reset during GRANT or RESP aborts the access; no response pulse after reset release.

Configuration
REQ-027 Macro RF_ARB_STARVE_GUARD_EN defined: counter increments each IDLE cycle with dbg_req=1 and core_we=1, saturates at STARVE_MAX; threshold reached when counter==STARVE_MAX; counter cleared on entering GRANT.
REQ-028 Macro undefined: no counter logic; debug granted only in IDLE cycles with core_we=0 (starvation possible).

Structure
REQ-029 Shared package holds the state enum (IDLE, GRANT, RESP), XLEN default and register-index width constant (5).
REQ-030 Single flat module; no sub-module; instantiated beside the register file inside the processor top.

Verification
REQ-031 Idle core, dbg_req write x5=0xDEADBEEF -> dbg_gnt next cycle, rf_we=1, rf_waddr=5, x5 reads 0xDEADBEEF afterwards.
REQ-032 Debug read x5 holding 0x12345678 -> dbg_gnt at cycle+1, dbg_rvalid=1 with dbg_rdata=0x12345678 at cycle+2, single pulse.
REQ-033 Debug write x0=0xFFFFFFFF then read x0 -> rf_we=0 in GRANT, dbg_rdata=0.
REQ-034 Guard enabled, STARVE_MAX=8, core_we=1 every cycle, dbg_req=1 -> grant after 8 pending cycles, core_stall=1 for exactly that cycle, core write lands next cycle; guard disabled -> no grant.
REQ-035 rst driven low during GRANT of a read -> all outputs 0 at once, no dbg_rvalid after release, state IDLE.

Source files
------------

// File: rtl/rf_access_arbiter_pkg.sv
// Shared types and constants for the register-file access arbiter.
// Holds the arbiter state encoding and the register-file geometry defaults.
package rf_access_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_access_arbiter.sv
// Arbitrates the register-file write port between core writeback and debug access.
// Optional starvation guard for debug requests: define RF_ARB_STARVE_GUARD_EN.
module rf_access_arbiter
    import rf_access_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 core_we,
    input  logic [REG_IDX_W-1:0] core_waddr,
    input  logic [XLEN-1:0]      core_wdata,

    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    input  logic [XLEN-1:0]      dbg_wdata,

    input  logic [XLEN-1:0]      rf_rdata,

    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [REG_IDX_W-1:0] rf_raddr,

    output logic                 dbg_gnt,
    output logic                 dbg_rvalid,
    output logic [XLEN-1:0]      dbg_rdata,
    output logic                 core_stall
);

    arb_state_t state;
    logic       starve_hit;
    logic       accept;

    // Debug only wins an IDLE cycle the core leaves free, unless it has waited too long.
    assign accept = (state == IDLE) && dbg_req && (!core_we || starve_hit);

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            // An abandoned request or a granted one both start the next wait from zero.
            if (accept || !dbg_req) begin
                starve_cnt <= '0;
            end else if (core_we && !starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_starve_max;

    assign unused_starve_max = (STARVE_MAX == 0);
    assign starve_hit        = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dbg_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (dbg_we) begin
                        state <= IDLE;
                    end else begin
                        state     <= RESP;
                        dbg_rdata <= (dbg_addr == '0) ? '0 : rf_rdata;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_gnt    = (state == GRANT);
    assign core_stall = (state == GRANT);
    assign dbg_rvalid = (state == RESP);
    assign rf_raddr   = dbg_addr;

    // NOTE: every output gets a default before the override so no latch is inferred.
    always_comb begin
        rf_we    = core_we && (core_waddr != '0);
        rf_waddr = core_waddr;
        rf_wdata = core_wdata;
        if (state == GRANT) begin
            rf_we    = dbg_we && (dbg_addr != '0);
            rf_waddr = dbg_addr;
            rf_wdata = dbg_wdata;
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed self-checking bench for rf_access_arbiter with a small register-file model.
// Expectations for the starvation guard follow RF_ARB_STARVE_GUARD_EN as built.
module tb_rf_access_arbiter;
    import rf_access_arbiter_pkg::*;

    localparam int              XLEN       = 32;
    localparam int              STARVE_MAX = 8;
    localparam logic [XLEN-1:0] X0_JUNK    = 32'hBAD0_0BAD;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_we;
    logic [4:0]      core_waddr;
    logic [XLEN-1:0] core_wdata;
    logic            dbg_req;
    logic            dbg_we;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic [XLEN-1:0] rf_rdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      rf_raddr;
    logic            dbg_gnt;
    logic            dbg_rvalid;
    logic [XLEN-1:0] dbg_rdata;
    logic            core_stall;

    logic [XLEN-1:0] regs [32];
    int              errors = 0;
    int              checks = 0;

    rf_access_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_raddr   (rf_raddr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .core_stall (core_stall)
    );

    always #5 clk = ~clk;

    // Register file: x0 read port returns junk so the arbiter's zero forcing is visible.
    always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;
    assign rf_rdata = (rf_raddr == 5'd0) ? X0_JUNK : regs[rf_raddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [XLEN-1:0] data);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = data;
        step();
        step();
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
        if (!we) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gnt_cyc;
        int stall_cnt;
        int gnt_seen;
        int k;
        logic prev_stall;
        logic landed;
        logic [XLEN-1:0] stall_data;

        rst        = 1'b0;
        core_we    = 1'b0;
        core_waddr = '0;
        core_wdata = '0;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;

        #2;
        check("rst_gnt",    dbg_gnt,    1'b0);
        check("rst_rvalid", dbg_rvalid, 1'b0);
        check("rst_stall",  core_stall, 1'b0);
        check("rst_rdata",  dbg_rdata,  32'h0);
        step();
        step();
        rst = 1'b1;
        step();

        // Debug write x5 with the core idle.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
        #1;
        check("wr_idle_gnt", dbg_gnt, 1'b0);
        step();
        check("wr_gnt",      dbg_gnt,    1'b1);
        check("wr_stall",    core_stall, 1'b1);
        check("wr_rf_we",    rf_we,      1'b1);
        check("wr_rf_waddr", rf_waddr,   5'd5);
        check("wr_rf_wdata", rf_wdata,   32'hDEADBEEF);
        step();
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        check("wr_after_gnt",    dbg_gnt,    1'b0);
        check("wr_after_rvalid", dbg_rvalid, 1'b0);
        check("wr_x5",           regs[5],    32'hDEADBEEF);

        // Debug read x5 holding 0x12345678.
        dbg_access(1'b1, 5'd5, 32'h12345678);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        #1;
        check("rd_idle_gnt", dbg_gnt, 1'b0);
        step();
        check("rd_gnt",      dbg_gnt,    1'b1);
        check("rd_rf_raddr", rf_raddr,   5'd5);
        check("rd_rf_we",    rf_we,      1'b0);
        check("rd_rvalid0",  dbg_rvalid, 1'b0);
        step();
        dbg_req = 1'b0;
        #1;
        check("rd_rvalid",   dbg_rvalid, 1'b1);
        check("rd_rdata",    dbg_rdata,  32'h12345678);
        check("rd_resp_gnt", dbg_gnt,    1'b0);
        step();
        check("rd_pulse_end", dbg_rvalid, 1'b0);
        check("rd_hold",      dbg_rdata,  32'h12345678);

        // x0: write suppressed, read forced to zero.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFFFFFF;
        step();
        check("x0_wr_gnt", dbg_gnt, 1'b1);
        check("x0_rf_we",  rf_we,   1'b0);
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
        step();
        step();
        dbg_req = 1'b0;
        #1;
        check("x0_rvalid", dbg_rvalid, 1'b1);
        check("x0_rdata",  dbg_rdata,  32'h0);
        step();

        // Core writeback path and x0 suppression; rf_raddr follows dbg_addr.
        core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'hAAAA5555; dbg_addr = 5'd9;
        #1;
        check("core_rf_we",    rf_we,    1'b1);
        check("core_rf_waddr", rf_waddr, 5'd3);
        check("core_rf_wdata", rf_wdata, 32'hAAAA5555);
        check("idle_raddr",    rf_raddr, 5'd9);
        core_waddr = 5'd0;
        #1;
        check("core_x0_we", rf_we, 1'b0);
        core_waddr = 5'd3;

        // Core priority: debug waits while core writes, wins the first free cycle.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h00000066;
        gnt_seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (dbg_gnt || core_stall || rf_waddr != 5'd3) gnt_seen++;
            step();
        end
        check("prio_core_wins", gnt_seen, 0);
        core_we = 1'b0;
        #1;
        check("prio_free_idle", dbg_gnt, 1'b0);
        step();
        check("prio_gnt",      dbg_gnt,  1'b1);
        check("prio_rf_waddr", rf_waddr, 5'd6);
        step();
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        check("prio_x6", regs[6], 32'h00000066);

        // Abandoned request clears the wait; a fresh 8-cycle wait must not be granted.
        core_we = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd8; dbg_wdata = 32'h88;
        gnt_seen = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (dbg_gnt) gnt_seen++;
            step();
        end
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (dbg_gnt) gnt_seen++;
            step();
        end
        check("abandon_no_gnt", gnt_seen, 0);
        dbg_req = 1'b0; core_we = 1'b0;
        step();

        // Starvation: core writes every cycle while debug waits.
        k = 0;
        gnt_cyc = -1;
        stall_cnt = 0;
        prev_stall = 1'b0;
        landed = 1'b0;
        stall_data = '0;
        core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h1000;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h77777777;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic stalled;
            logic granted;
            #1;
            stalled = core_stall;
            granted = dbg_gnt;
            if (granted && gnt_cyc < 0) gnt_cyc = cyc;
            if (stalled) begin
                stall_cnt++;
                stall_data = 32'h1000 + 32'(k);
            end
            if (prev_stall) begin
                check("starve_land_we",    rf_we,    1'b1);
                check("starve_land_waddr", rf_waddr, 5'd3);
                check("starve_land_wdata", rf_wdata, stall_data);
                landed = 1'b1;
            end
            prev_stall = stalled;
            step();
            if (!stalled) k++;
            core_wdata = 32'h1000 + 32'(k);
            if (granted) begin
                dbg_req = 1'b0;
                dbg_we  = 1'b0;
            end
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        check("starve_gnt_cyc",   gnt_cyc,   STARVE_MAX + 1);
        check("starve_stall_cnt", stall_cnt, 1);
        check("starve_landed",    landed,    1'b1);
        check("starve_x7",        regs[7],   32'h77777777);
`else
        check("nostarve_gnt",   gnt_cyc < 0, 1'b1);
        check("nostarve_stall", stall_cnt,   0);
`endif
        dbg_req = 1'b0; dbg_we = 1'b0; core_we = 1'b0;
        step();

        // Reset during GRANT of a read aborts it.
        dbg_access(1'b0, 5'd5, '0);
        check("pre_rst_rdata", dbg_rdata, 32'h12345678);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        step();
        check("rst_rd_gnt", dbg_gnt, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_gnt",    dbg_gnt,    1'b0);
        check("arst_stall",  core_stall, 1'b0);
        check("arst_rvalid", dbg_rvalid, 1'b0);
        check("arst_rdata",  dbg_rdata,  32'h0);
        check("arst_rf_we",  rf_we,      1'b0);
        dbg_req = 1'b0;
        step();
        rst = 1'b1;
        gnt_seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (dbg_rvalid || dbg_gnt) gnt_seen++;
            step();
        end
        check("arst_no_resp", gnt_seen,  0);
        check("arst_state",   dut.state, IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
